// File: rtl/spi_reg_master_if.sv
// Command/response bus of spi_reg_master: one command in flight, one-cycle response strobe.
interface spi_reg_master_if #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [REG_W-1:0]  cmd_wdata;
  logic              rsp_valid;
  logic [REG_W-1:0]  rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/spi_reg_master.sv
// SPI mode-0 register initiator: one write/read frame per command, registered pins.
// Define SPI_REG_MASTER_LOOPBACK_EN to capture the driven spi_mosi instead of spi_miso.
module spi_reg_master #(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  spi_reg_master_if.slave  bus,
  output logic             spi_cs_n,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int FRAME_W = 8 + REG_W;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [REG_W-1:0]     rx_q, rx_d;
  logic                 wr_q, wr_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 ready_q, ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [REG_W-1:0]     rdata_q, rdata_d;

  logic                 fire;
  logic                 div_last;
  logic                 sample;
  logic [7:0]           cmd_byte;
  logic [REG_W-1:0]     wdata_sel;
  logic [FRAME_W-1:0]   frame;

  assign fire     = bus.cmd_valid && ready_q;
  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

`ifdef SPI_REG_MASTER_LOOPBACK_EN
  assign sample = mosi_q;
`else
  assign sample = spi_miso;
`endif

  // Command byte: write flag in bit 7, zero padding, address in the low bits.
  always_comb begin
    cmd_byte    = 8'(bus.cmd_addr);
    cmd_byte[7] = bus.cmd_write;
    wdata_sel   = bus.cmd_write ? bus.cmd_wdata : '0;
    frame       = {cmd_byte, wdata_sel};
  end

  always_comb begin
    // NOTE: every signal gets its hold/default value first so no latch is inferred.
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    wr_d        = wr_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = ena && !fire;
        if (fire) begin
          state_d = ST_SETUP;
          div_d   = '0;
          bit_d   = '0;
          tx_d    = frame;
          wr_d    = bus.cmd_write;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = frame[FRAME_W-1];
        end
      end

      ST_SETUP: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      // Each SPI period is a low half then a high half of CLK_DIV cycles.
      ST_SHIFT: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = REG_W'({rx_q, sample});
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_W'(FRAME_W - 1)) begin
              state_d = ST_HOLD;
            end else begin
              bit_d  = bit_q + BIT_W'(1);
              tx_d   = tx_q << 1;
              mosi_d = tx_d[FRAME_W-1];
            end
          end
        end
      end

      ST_HOLD: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d       = '0;
          state_d     = ST_GAP;
          cs_n_d      = 1'b1;
          mosi_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = wr_q ? '0 : rx_q;
        end
      end

      ST_GAP: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      wr_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      wr_q        <= wr_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign spi_cs_n      = cs_n_q;
  assign spi_clk       = sclk_q;
  assign spi_mosi      = mosi_q;
  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Self-checking bench for spi_reg_master: mode-0 slave model plus a response scoreboard.
module tb_spi_reg_master;

  localparam int ADDR_W  = 3;
  localparam int REG_W   = 8;
  localparam int CLK_DIV = 4;
  localparam int FRAME_W = 8 + REG_W;
  localparam int EXP_LAT = 1 + CLK_DIV * (2 * FRAME_W + 2);

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic ena = 1'b0;
  logic spi_cs_n, spi_clk, spi_mosi;
  logic spi_miso = 1'b0;

  always #5 clk = ~clk;

  spi_reg_master_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  spi_reg_master #(.ADDR_W(ADDR_W), .REG_W(REG_W), .CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .bus      (bus),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Slave model: mode 0, first bit on cs fall, shifts out on falling spi_clk.
  logic [REG_W-1:0]   slave_data = '0;
  logic [FRAME_W-1:0] s_frame = '0;
  logic [FRAME_W-1:0] last_frame = '0;
  int                 s_cnt = 0;
  int                 last_rises = 0;
  logic               p_cs = 1'b1;
  logic               p_clk = 1'b0;

  function automatic logic slave_bit(input int k);
    if (k < 8 || k >= FRAME_W) return 1'b0;
    return slave_data[REG_W-1-(k-8)];
  endfunction

  always @(spi_cs_n or spi_clk) begin
    if (spi_cs_n) begin
      if (!p_cs) begin
        last_frame = s_frame;
        last_rises = s_cnt;
      end
    end else if (p_cs) begin
      s_cnt    = 0;
      s_frame  = '0;
      spi_miso = slave_bit(0);
    end else if (spi_clk && !p_clk) begin
      s_frame = {s_frame[FRAME_W-2:0], spi_mosi};
      s_cnt++;
    end else if (!spi_clk && p_clk) begin
      spi_miso = slave_bit(s_cnt);
    end
    p_cs  = spi_cs_n;
    p_clk = spi_clk;
  end

  // Monitor: handshakes, responses (scoreboard pop), pin edge timestamps.
  logic [REG_W-1:0] exp_q[$];
  int   hs_cnt = 0, hs_cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
  int   cs_fall_cyc = 0, first_rise_cyc = 0;
  logic m_cs = 1'b1, m_sclk = 1'b0, rise_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) begin
      hs_cnt++;
      hs_cyc = cyc;
    end
    if (bus.rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_q.pop_front()));
    end
    if (m_cs && !spi_cs_n) begin
      cs_fall_cyc = cyc;
      rise_seen   = 1'b0;
    end
    if (!m_sclk && spi_clk && !rise_seen) begin
      first_rise_cyc = cyc;
      rise_seen      = 1'b1;
    end
    m_cs   = spi_cs_n;
    m_sclk = spi_clk;
  end

  function automatic logic [FRAME_W-1:0] exp_frame(input logic w, input logic [ADDR_W-1:0] a,
                                                   input logic [REG_W-1:0] d);
    logic [7:0] c;
    c    = 8'(a);
    c[7] = w;
    return {c, w ? d : REG_W'(0)};
  endfunction

  function automatic logic [REG_W-1:0] exp_read();
`ifdef SPI_REG_MASTER_LOOPBACK_EN
    return '0;
`else
    return slave_data;
`endif
  endfunction

  task automatic drive(input logic w, input logic [ADDR_W-1:0] a, input logic [REG_W-1:0] d,
                       input bit push);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    if (push) exp_q.push_back(w ? REG_W'(0) : exp_read());
  endtask

  // Deassert on the handshake edge and scramble fields to prove they were latched.
  task automatic release_cmd();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = ~bus.cmd_write;
    bus.cmd_addr  = ~bus.cmd_addr;
    bus.cmd_wdata = ~bus.cmd_wdata;
  endtask

  task automatic wait_hs(input string tag);
    int n0 = hs_cnt;
    for (int i = 0; i < 400 && hs_cnt == n0; i++) begin
      @(negedge clk); #1;
    end
    check(tag, 32'(hs_cnt), 32'(n0 + 1));
  endtask

  task automatic wait_rsp(input string tag);
    int n0 = rsp_cnt;
    for (int i = 0; i < EXP_LAT + 50 && rsp_cnt == n0; i++) begin
      @(negedge clk); #1;
    end
    check(tag, 32'(rsp_cnt), 32'(n0 + 1));
  endtask

  task automatic wait_rises(input string tag, input int n);
    for (int i = 0; i < 400 && !(!spi_cs_n && s_cnt >= n); i++) begin
      @(negedge clk); #1;
    end
    check(tag, 32'(s_cnt), 32'(n));
  endtask

  task automatic txn(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                     input logic [REG_W-1:0] d, input logic [REG_W-1:0] sd);
    slave_data = sd;
    drive(w, a, d, 1'b1);
    wait_hs({tag, "_hs"});
    release_cmd();
    wait_rsp({tag, "_rsp"});
    check({tag, "_frame"}, 32'(last_frame), 32'(exp_frame(w, a, d)));
    check({tag, "_rises"}, 32'(last_rises), 32'(FRAME_W));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, r1, hs2;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    ena = 1'b1;

    // Reset values, then ready on the first cycle after release.
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_clk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    rstb = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    // Write addr 5 / 0xA7 with cycle accounting.
    txn("wr5", 1'b1, 3'd5, 8'hA7, 8'h00);
    check("wr5_cs_fall", 32'(cs_fall_cyc - hs_cyc), 32'd1);
    check("wr5_first_rise", 32'(first_rise_cyc - hs_cyc), 32'(1 + 2 * CLK_DIV));
    check("wr5_latency", 32'(rsp_cyc - hs_cyc), 32'(EXP_LAT));

    // Read addr 3 from a slave returning 0x5C; response must hold afterwards.
    txn("rd3", 1'b0, 3'd3, 8'hFF, 8'h5C);
    check("rd3_latency", 32'(rsp_cyc - hs_cyc), 32'(EXP_LAT));
    repeat (6) @(negedge clk);
    check("rd3_rdata_hold", 32'(bus.rsp_rdata), 32'(exp_read()));

    // Back-to-back: cmd_valid held across two commands.
    slave_data = 8'h00;
    drive(1'b1, 3'd1, 8'h11, 1'b1);
    wait_hs("b2b_hs1");
    @(posedge clk); #1;
    slave_data    = 8'hC3;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 3'd2;
    bus.cmd_wdata = 8'h00;
    exp_q.push_back(exp_read());
    wait_rsp("b2b_rsp1");
    r1 = rsp_cyc;
    wait_hs("b2b_hs2");
    hs2 = hs_cyc;
    check("b2b_gap", 32'(hs2 - r1), 32'(CLK_DIV + 1));
    release_cmd();
    wait_rsp("b2b_rsp2");
    check("b2b_cs_high", 32'((cs_fall_cyc - r1) >= CLK_DIV), 32'd1);
    check("b2b_frame2", 32'(last_frame), 32'(exp_frame(1'b0, 3'd2, 8'h00)));

    // Drop ena at data bit 6: frame completes, no new acceptance until ena returns.
    slave_data = 8'h00;
    drive(1'b1, 3'd6, 8'h3C, 1'b1);
    wait_hs("ena_hs");
    release_cmd();
    wait_rises("ena_bit6", 8 + 6);
    ena = 1'b0;
    wait_rsp("ena_rsp");
    check("ena_frame", 32'(last_frame), 32'(exp_frame(1'b1, 3'd6, 8'h3C)));
    slave_data = 8'h96;
    n0 = hs_cnt;
    drive(1'b0, 3'd4, 8'h00, 1'b1);
    repeat (30) @(negedge clk);
    #1;
    check("ena_low_ready", 32'(bus.cmd_ready), 32'd0);
    check("ena_low_no_hs", 32'(hs_cnt), 32'(n0));
    @(posedge clk); #1;
    ena = 1'b1;
    wait_hs("ena_back_hs");
    release_cmd();
    wait_rsp("ena_back_rsp");

    // Async reset at bit 10: pins go idle at once, no response.
    slave_data = 8'hE1;
    drive(1'b0, 3'd7, 8'h00, 1'b0);
    wait_hs("rst_hs");
    release_cmd();
    wait_rises("rst_bit10", 10);
    n0 = rsp_cnt;
    @(posedge clk); #3;
    rstb = 1'b0;
    #1;
    check("midrst_cs_n", 32'(spi_cs_n), 32'd1);
    check("midrst_sclk", 32'(spi_clk), 32'd0);
    repeat (5) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_cnt), 32'(n0));
    check("midrst_ready", 32'(bus.cmd_ready), 32'd0);
    rstb = 1'b1;
    txn("rd6", 1'b0, 3'd6, 8'h00, 8'h3B);

    // A few random transactions.
    for (int i = 0; i < 4; i++) begin
      txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
          REG_W'($urandom), REG_W'($urandom));
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

Single-clock SPI controller (mode 0) that issues register write and read transactions to a `spi_reg`-style register-bank peripheral. It is the initiator counterpart of the on-chip SPI register wrapper. It accepts one command at a time over a valid/ready handshake, generates `spi_cs_n`, `spi_clk` and `spi_mosi` from the system clock, captures `spi_miso`, and returns the read data with a one-cycle response strobe. It is used for chip-to-chip configuration and for loopback bring-up of the register wrapper.

## Interface
- `ADDR_W`, 3: register address width; legal range 1..7.
- `REG_W`, 8: register data width; legal range 1..32.
- `CLK_DIV`, 4: SPI half-period in `clk` cycles; legal minimum 2.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rstb` in 1: asynchronous active-low reset.
- `ena` in 1: block enable; gates acceptance of new commands only.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = register write, 0 = register read.
- `cmd_addr` in `ADDR_W`: register address.
- `cmd_wdata` in `REG_W`: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse at transaction end, for reads and writes.
- `rsp_rdata` out `REG_W`: read data, valid with `rsp_valid`; all zeros for writes.
- `spi_cs_n` out 1: chip select, active low.
- `spi_clk` out 1: SPI clock, idle low.
- `spi_mosi` out 1: serial data out.
- `spi_miso` in 1: serial data in.

## Operation
- Frame is `8 + REG_W` bits, MSB first.
  - Command byte: bit7 = `cmd_write`, bits[6:ADDR_W] = 0, bits[ADDR_W-1:0] = `cmd_addr`.
  - Data phase: `REG_W` bits. On a write the controller drives `cmd_wdata`. On a read it drives 0 and captures `spi_miso`.
- Command fields are latched on the handshake cycle. Later input changes have no effect.
- FSM states:
  - IDLE: `cmd_ready = ena`. On handshake → SETUP.
  - SETUP: `spi_cs_n` is low. The first bit is on `spi_mosi`. Lasts `CLK_DIV` cycles → SHIFT.
  - SHIFT: Runs `8 + REG_W` SPI periods of `2*CLK_DIV` cycles each. `spi_clk` is high in the second half of each period.
    - `spi_miso` is sampled on the `clk` cycle where `spi_clk` rises.
    - `spi_mosi` advances on the cycle where `spi_clk` falls, except after the last bit.
    - After the last falling edge → HOLD.
  - HOLD: `spi_clk` is low and `spi_cs_n` is still low for `CLK_DIV` cycles. Then `spi_cs_n` goes high, `rsp_valid` pulses and `rsp_rdata` updates → GAP.
  - GAP: `spi_cs_n` is high for `CLK_DIV` cycles → IDLE.
- Read data is the last `REG_W` bits sampled, MSB first. Command-phase samples are discarded.
- `rsp_rdata` holds its value until the next response.
- Deasserting `ena` mid-transaction does not abort it. The response is still produced, but no new command is accepted until `ena` returns.

## Timing
- Reset values:
  - `spi_cs_n` = 1, `spi_clk` = 0, `spi_mosi` = 0.
  - `cmd_ready` = 0 while `rstb` is low, then follows `ena` in IDLE.
  - `rsp_valid` = 0, `rsp_rdata` = 0.
- All outputs are registered.
- Cycle accounting, with handshake at cycle 0:
  - `spi_cs_n` falls at cycle 1.
  - First `spi_clk` rise at cycle `1 + 2*CLK_DIV`.
  - `rsp_valid` at cycle `1 + CLK_DIV*(2*(8+REG_W) + 2)`. With defaults this is cycle 137.
- Next handshake is possible at the earliest `CLK_DIV + 1` cycles after `rsp_valid`.
- Back-to-back `cmd_valid` is accepted only in IDLE. `cmd_ready` is 0 from the handshake cycle through the end of GAP.
- Asynchronous reset mid-frame forces `spi_cs_n` high and `spi_clk` low immediately. The transaction is dropped and no `rsp_valid` is produced.

## Configuration
- `SPI_REG_MASTER_LOOPBACK_EN`
  - Defined: the capture path samples the internally driven `spi_mosi` instead of `spi_miso`, and `spi_miso` is ignored. A read of address A therefore returns the data-phase bits the controller drove, which are all zeros. Write responses still report zeros.
  - Undefined: `spi_miso` is sampled as specified.
  - Pin-level timing is identical in both builds.

## Test plan
- Reset with `rstb` = 0, then release with `ena` = 1 → all outputs at their reset values and `cmd_ready` = 1 on the first cycle after release.
- Write addr 5, data 0xA7 with defaults → MOSI frame 0x85 then 0xA7. 16 rising edges with `spi_cs_n` low. `rsp_valid` at cycle 137 with `rsp_rdata` = 0x00.
- Read addr 3 with a slave model returning 0x5C → MOSI command byte 0x03, data bits 0. `rsp_rdata` = 0x5C.
- Hold `cmd_valid` high for two commands → second handshake exactly `CLK_DIV + 1` cycles after the first `rsp_valid`. `spi_cs_n` is high for at least `CLK_DIV` cycles between frames.
- Drop `ena` at bit 6 of the data phase → the frame completes and `rsp_valid` pulses. `cmd_ready` stays 0 until `ena` = 1.
- Assert `rstb` low at bit 10 → `spi_cs_n` = 1 and `spi_clk` = 0 asynchronously, no `rsp_valid`. A fresh read after release completes normally.
